lbp_write_ctrl: RTL

Output-side counterpart of the LBP gray-image address sequencer. It accepts computed LBP codes with their pixel address from the LBP datapath, buffers them in a small FIFO, and drives the LBP result memory write port (lbp_valid/lbp_addr/lbp_data). It tracks completion of all interior pixels and raises finish. Border pixels are never written.

---
 rtl/lbp_write_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lbp_write_ctrl.sv
// LBP result write controller: buffers interior-pixel LBP codes in a small FIFO, drives the
// result memory write port, and raises finish once every interior pixel has been written.
module lbp_write_ctrl #(
  parameter int unsigned IMG_DIM    = 128,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AddrW     = 2 * $clog2(IMG_DIM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AddrW-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              lbp_busy,
  output logic              lbp_valid,
  output logic [AddrW-1:0]  lbp_addr,
  output logic [DATA_W-1:0] lbp_data,
  output logic [AddrW-1:0]  wr_count,
  output logic              err_addr,
  output logic              finish
);

  localparam int unsigned       CoordW    = $clog2(IMG_DIM);
  localparam int unsigned       PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned       Total     = (IMG_DIM - 2) * (IMG_DIM - 2);
  localparam logic [AddrW-1:0]  TotalCnt  = AddrW'(Total);
  localparam logic [AddrW-1:0]  LastCnt   = AddrW'(Total - 1);
  localparam logic [CoordW-1:0] EdgeCoord = CoordW'(IMG_DIM - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0]  acc_cnt_q, acc_cnt_d;
  logic [AddrW-1:0]  wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;
  logic              lbp_valid_q;
  logic [AddrW-1:0]  lbp_addr_q;
  logic [DATA_W-1:0] lbp_data_q;

  logic [AddrW-1:0]  mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];

  logic [CoordW-1:0] row, col;
  logic [PtrW-1:0]   wr_idx, rd_idx;
  logic              fifo_empty, fifo_full;
  logic              is_border, start_ok, xfer, push, pop;

  assign row    = in_addr[AddrW-1:CoordW];
  assign col    = in_addr[CoordW-1:0];
  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign is_border = (row == '0) || (row == EdgeCoord) || (col == '0) || (col == EdgeCoord);
  assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));

  // in_ready depends only on registered state, so a full FIFO never sees a push.
  assign in_ready = (state_q == StRun) && !fifo_full;
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && !is_border;
  assign pop      = !fifo_empty && !lbp_busy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun:   if (push && (acc_cnt_q == LastCnt)) state_d = StDrain;
      StDrain: if (fifo_empty && (wr_cnt_q == TotalCnt)) state_d = StDone;
      StDone:  if (start_ok) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{PtrW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{PtrW{1'b0}}, pop};
    acc_cnt_d = acc_cnt_q + AddrW'(push);
    wr_cnt_d  = wr_cnt_q + AddrW'(pop);
    err_d     = err_q || (xfer && is_border);
    if (start_ok) begin
      acc_cnt_d = '0;
      wr_cnt_d  = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_idx] <= in_addr;
      mem_data[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
    end else begin
      lbp_valid_q <= pop;
      if (pop) begin
        lbp_addr_q <= mem_addr[rd_idx];
        lbp_data_q <= mem_data[rd_idx];
      end
    end
  end

  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign wr_count  = wr_cnt_q;
  assign err_addr  = err_q;
  assign finish    = (state_q == StDone);

endmodule
